// File: rtl/train_pkg.sv
// Shared constants and types for the train controller: sensor numbering and the
// queued event format.
package train_pkg;
  localparam int unsigned NUM_SENSORS = 6;
  localparam int unsigned SID_W       = 3;

  localparam logic EV_RISE = 1'b1;
  localparam logic EV_FALL = 1'b0;

  localparam logic [SID_W-1:0] SENSOR_S1 = 3'd1;
  localparam logic [SID_W-1:0] SENSOR_S2 = 3'd2;
  localparam logic [SID_W-1:0] SENSOR_S3 = 3'd3;
  localparam logic [SID_W-1:0] SENSOR_S4 = 3'd4;
  localparam logic [SID_W-1:0] SENSOR_S5 = 3'd5;
  localparam logic [SID_W-1:0] SENSOR_S6 = 3'd6;

  typedef struct packed {
    logic [SID_W-1:0] sensor;
    logic             level;
  } event_t;
endpackage

// File: rtl/sensor_debounce.sv
// One sensor line: 2-flop synchronizer, mismatch counter and stable level.
// `change` is high in the cycle whose edge will accept the new level.
module sensor_debounce
  import train_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic change
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  assign change = (sync2 != stable) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sensor_event_capture.sv
// Debounces sensors S1-S6 and queues every accepted level change as an event
// in a first-word-fall-through FIFO popped with a valid/ready handshake.
module sensor_event_capture
  import train_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic             clk_100mhz,
  input  logic             rst,
  input  logic             S1,
  input  logic             S2,
  input  logic             S3,
  input  logic             S4,
  input  logic             S5,
  input  logic             S6,
  input  logic             ev_ready,
  input  logic             ovf_clr,
  output logic             ev_valid,
  output logic [SID_W-1:0] ev_sensor,
  output logic             ev_level,
  output logic [5:0]       sensor_state,
  output logic             overflow
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [NUM_SENSORS-1:0] raw;
  logic [NUM_SENSORS-1:0] stable;
  logic [NUM_SENSORS-1:0] change;
  logic [NUM_SENSORS-1:0] pending;
  logic [NUM_SENSORS-1:0] grant;
  logic                   push;
  event_t                 push_ev;

  event_t        mem [FIFO_DEPTH];
  event_t        head;
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          wr;
  logic          drop;

  assign raw = {S6, S5, S4, S3, S2, S1};

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_deb
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk_100mhz),
      .rst   (rst),
      .raw   (raw[i]),
      .stable(stable[i]),
      .change(change[i])
    );
  end

  assign sensor_state = stable;

  // Fixed priority: lowest-numbered pending sensor is pushed this cycle.
  always_comb begin
    grant   = '0;
    push    = 1'b0;
    push_ev = '0;
    for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
      if (pending[i] && !push) begin
        grant[i]       = 1'b1;
        push           = 1'b1;
        push_ev.sensor = SENSOR_S1 + SID_W'(i);
        push_ev.level  = stable[i];
      end
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = ev_valid && ev_ready;
  assign wr    = push && (!full || pop);
  assign drop  = push && full && !pop;

  assign head      = mem[rptr[AW-1:0]];
  assign ev_valid  = !empty;
  assign ev_sensor = ev_valid ? head.sensor : '0;
  assign ev_level  = ev_valid & head.level;

  always_ff @(posedge clk_100mhz) begin
    if (wr) mem[wptr[AW-1:0]] <= push_ev;
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      pending  <= '0;
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= (pending & ~grant) | change;
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end
endmodule

// File: doc/sensor_event_capture.md
# sensor_event_capture

Front end of the train controller for the six track sensors S1–S6. Synchronizes and debounces each raw sensor line and converts every debounced transition into a queued event (sensor number, edge direction). The controller FSM pops events with a valid/ready handshake. Continuous levels are also exported for the display and occupancy logic.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: stable-mismatch cycles required to accept a new level (10 ms at 100 MHz); legal range ≥ 8.
- FIFO_DEPTH, 8: event queue entries; a power of two, ≥ 2.

Ports:
- clk_100mhz  in  1  system clock; the single clock domain.
- rst  in  1  synchronous, active-high reset.
- S1, S2, S3, S4, S5, S6  in  1 each  raw asynchronous sensor lines; 1 = train present.
- ev_ready  in  1  consumer accepts the head event this cycle.
- ovf_clr  in  1  clears the overflow flag.
- ev_valid  out  1  queue non-empty; head event presented.
- ev_sensor  out  3  head event sensor number, 1–6; 0 when empty.
- ev_level  out  1  head event new level: 1 = rising (arrival), 0 = falling (departure); 0 when empty.
- sensor_state  out  6  debounced levels; bit i-1 = Si.
- overflow  out  1  sticky flag: an event was dropped because the queue was full.

## Operation
- Per sensor: a 2-flop synchronizer feeds a debounce counter.
  - The counter clears whenever synced == stable.
  - While synced != stable, the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and a mismatch still holds, then on that edge: stable <= synced, the counter clears, and the sensor's pending bit is set.
- Pulses and glitches shorter than DEBOUNCE_CYCLES cycles produce no event and no sensor_state change.
- Arbiter: each cycle it takes the lowest-numbered pending sensor, clears that pending bit, and pushes {sensor number, stable level} into the FIFO.
  - Only one push per cycle.
  - With DEBOUNCE_CYCLES ≥ 8 and six sensors, a pending bit is never overwritten before service.
- FIFO: first-word-fall-through, so ev_sensor/ev_level always show the head entry.
  - A pop happens when ev_valid && ev_ready.
  - ev_ready while empty is ignored.
- Full queue:
  - A push with no simultaneous pop drops the event: pending is still cleared, overflow <= 1, and queue contents are unchanged.
  - Push and pop in the same cycle while full both succeed; overflow is unaffected.
- Overflow behaviour:
  - When ovf_clr and a new drop coincide, overflow stays 1 (set wins).
  - Otherwise ovf_clr clears overflow on the next edge.
- Reset values: ev_valid 0, ev_sensor 0, ev_level 0, sensor_state 0, overflow 0. Synchronizers, counters, pending bits and the FIFO all clear.
- Reset mid-operation discards queued and pending events.
- A sensor held at 1 through reset release yields a rising event after the normal debounce latency, because stable restarts at 0.

## Timing
- Let edge 0 be the first edge sampling a new raw level that then holds steady.
- Sync stage 2 shows the new level after edge 1.
- The counter reaches DEBOUNCE_CYCLES-1 after edge DEBOUNCE_CYCLES.
- At edge DEBOUNCE_CYCLES+1, stable and sensor_state update and pending is set.
- At edge DEBOUNCE_CYCLES+2, the FIFO is written. ev_valid is high in the following cycle if the queue was empty.
- Total latency is DEBOUNCE_CYCLES+2 edges after edge 0, plus one cycle per lower-numbered sensor pending in the same cycle.
- Pop: ev_valid/ev_sensor/ev_level reflect the next entry (or empty/zero) in the cycle after the handshake edge.
- Throughput: one push and one pop per cycle.

## Structure
- Shared package train_pkg:
  - NUM_SENSORS = 6.
  - Sensor-ID width = 3.
  - Event encoding constants EV_RISE = 1, EV_FALL = 0.
  - Sensor-ID constants SENSOR_S1..SENSOR_S6 = 1..6.
- One sub-module, sensor_debounce: synchronizer, counter, stable register and change strobe. Instantiate it six times in a generate loop.
- Arbiter and FIFO stay inline in sensor_event_capture.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 8 and FIFO_DEPTH = 4. ev_ready is held at 1 except where stated.
- S1 0→1 held → sensor_state[0] = 1 at edge 9, ev_valid with ev_sensor = 1, ev_level = 1 one cycle after edge 10; single event. S1 then 1→0 → event {1, 0}.
- S3 high for 5 cycles then low → no event, sensor_state stays 0.
- S2 and S5 rise on the same edge → events popped in order {2, 1} then {5, 1}, one cycle apart.
- ev_ready = 0; toggle S1–S6 to create 6 events → queue holds the first 4 (S1–S4 rising), overflow = 1. Raise ev_ready → exactly 4 pops in order, then ev_valid = 0. Pulse ovf_clr → overflow = 0.
- ev_ready = 0; queue full; ev_ready = 1 on the cycle a new event pushes → no drop, overflow stays 0, order preserved.
- Queue holding 2 events, assert rst for 1 cycle with S4 held at 1 → all outputs 0 after reset; event {4, 1} appears DEBOUNCE_CYCLES+2 edges after reset release.
